div_unit: RTL and testbench

- Iterative 32-bit integer divider implementing the RV32M DIV, DIVU, REM and REMU operations.
- Sits directly downstream of the core control FSM:
  - consumes the div_start pulse issued in EXECUTE;
  - drives div_busy, which holds the FSM in DIV_WAIT;
  - the result is valid for the WRITE_BACK cycle.
- Radix-2 restoring algorithm on magnitudes, followed by a sign-fix cycle.

---
 rtl/div_unit.sv | 199 +++++++++++++++++++
 tb/tb_div_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are captured on an accepted start. The result and a one-cycle
// done pulse appear in the first idle cycle after busy falls.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   div_start   one-cycle request, sampled only while idle
//   div_op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1, rs2    dividend, divisor
//   div_busy    high while an operation is in flight
//   div_done    one-cycle pulse, result valid
//   div_result  quotient or remainder, held until the next result
//
// Optional build macro: DIV_EARLY_OUT_EN. When defined, operands whose
// dividend magnitude is below the divisor magnitude finish in one busy
// cycle instead of 33.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPECIAL,
        S_CALC,
        S_SIGN
    } state_t;

    state_t state;
    state_t state_nx;

    logic             rem_sel_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  spec_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;
    logic             done_q;

    // Capture-time decode of the incoming operands.
    logic            is_signed;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            overflow;
    logic            early;
    logic            go_special;
    logic [XLEN-1:0] spec_val;

    always_comb begin
        is_signed = ~div_op[0];
        rs1_mag   = (is_signed && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
        rs2_mag   = (is_signed && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;
        div_zero  = (rs2 == '0);
        overflow  = is_signed && (rs1 == INT_MIN) && (rs2 == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = (rs1_mag < rs2_mag);
`else
        early     = 1'b0;
`endif
        go_special = div_zero | overflow | early;

        // Early-out result: quotient 0, remainder is the original rs1.
        spec_val = div_op[1] ? rs1 : '0;
        if (div_zero) begin
            spec_val = div_op[1] ? rs1 : '1;
        end else if (overflow) begin
            spec_val = div_op[1] ? '0 : INT_MIN;
        end
    end

    // One restoring step. The shifted remainder needs XLEN+1 bits, since
    // an unsigned divisor can exceed 2^(XLEN-1).
    logic [XLEN:0]   rem_tmp;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx;

    always_comb begin
        rem_tmp = {rem_q, dvd_q[XLEN-1]};
        diff    = rem_tmp - {1'b0, dsr_q};
        q_bit   = ~diff[XLEN];
        rem_nx  = q_bit ? diff[XLEN-1:0] : rem_tmp[XLEN-1:0];
    end

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_busy = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (div_start) begin
                    state_nx = go_special ? S_SPECIAL : S_CALC;
                end
            end
            S_SPECIAL: begin
                div_busy = 1'b1;
                state_nx = S_IDLE;
            end
            S_CALC: begin
                div_busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_nx = S_SIGN;
                end
            end
            S_SIGN: begin
                div_busy = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath registers. dvd_q doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            spec_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (div_start) begin
                        rem_sel_q <= div_op[1];
                        neg_quo_q <= is_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        neg_rem_q <= is_signed & rs1[XLEN-1];
                        dvd_q     <= rs1_mag;
                        dsr_q     <= rs2_mag;
                        rem_q     <= '0;
                        spec_q    <= spec_val;
                        cnt_q     <= '0;
                    end
                end
                S_SPECIAL: begin
                    result_q <= spec_q;
                    done_q   <= 1'b1;
                end
                S_CALC: begin
                    rem_q <= rem_nx;
                    dvd_q <= {dvd_q[XLEN-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_SIGN: begin
                    result_q <= rem_sel_q ? rem_fix : quo_fix;
                    done_q   <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_done   = done_q;
    assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    int errors;
    int checks;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 0;
`endif

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_start  (div_start),
        .div_op     (div_op),
        .rs1        (rs1),
        .rs2        (rs2),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V division semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? 32'(ua % ub) : 32'(ua / ub);
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        longint ma;
        longint mb;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = op[0] ? longint'(a) : longint'($signed(a));
        mb = op[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (EO == 1 && ma < mb) return 1;
        return 33;
    endfunction

    // mode 0: plain op. mode 1: stray start in busy cycle 10.
    // mode 2: reset asserted in busy cycle 10.
    task automatic do_op(input int mode, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic dn, output logic dn2);
        @(negedge clk);
        div_op = op;
        rs1 = a;
        rs2 = b;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        div_op = 2'($urandom);
        lat = 0;
        while (div_busy === 1'b1 && lat < 200) begin
            lat++;
            div_start = 1'b0;
            if (lat == 10 && mode == 1) begin
                div_start = 1'b1;
                div_op = 2'b01;
                rs1 = 32'd9;
                rs2 = 32'd3;
            end
            if (lat == 10 && mode == 2) reset = 1'b0;
            @(negedge clk);
        end
        div_start = 1'b0;
        reset = 1'b1;
        dn = div_done;
        res = div_result;
        @(negedge clk);
        dn2 = div_done;
    endtask

    task automatic run_check(input string name, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat;
        logic dn;
        logic dn2;
        do_op(0, op, a, b, res, lat, dn, dn2);
        chk({name, " result"}, res, exp);
        chk({name, " busy_cycles"}, 32'(lat), 32'(exp_lat));
        chk({name, " done"}, {31'd0, dn}, 32'd1);
        chk({name, " done_width"}, {31'd0, dn2}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int lat;
        logic dn;
        logic dn2;
        logic any_done;

        errors = 0;
        checks = 0;

        vecs[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, 33};
        vecs[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, 33};
        vecs[2]  = '{2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33};
        vecs[3]  = '{2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33};
        vecs[4]  = '{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{2'b10, 32'd5, 32'd0, 32'd5, 1};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                     (EO == 1) ? 1 : 33};
        vecs[9]  = '{2'b01, 32'd3, 32'd10, 32'd0, (EO == 1) ? 1 : 33};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001,
                     32'h7FFF_FFFE, 33};
        vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33};
        vecs[12] = '{2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[13] = '{2'b11, 32'd7, 32'd0, 32'd7, 1};
        vecs[14] = '{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[15] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};

        reset = 1'b0;
        div_start = 1'b0;
        div_op = 2'b00;
        rs1 = '0;
        rs2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("reset busy", {31'd0, div_busy}, 32'd0);
        chk("reset done", {31'd0, div_done}, 32'd0);
        chk("reset result", div_result, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                      vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Stray start while busy must not disturb the running op.
        do_op(1, 2'b01, 32'd100, 32'd7, res, lat, dn, dn2);
        chk("ignore result", res, 32'd14);
        chk("ignore busy_cycles", 32'(lat), 32'd33);
        chk("ignore done", {31'd0, dn}, 32'd1);

        // Reset mid-operation abandons it without a done pulse.
        do_op(2, 2'b01, 32'd100, 32'd7, res, lat, dn, dn2);
        chk("midreset busy_cycles", 32'(lat), 32'd10);
        chk("midreset busy", {31'd0, div_busy}, 32'd0);
        chk("midreset result", res, 32'd0);
        chk("midreset done", {31'd0, dn | dn2}, 32'd0);
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any_done = any_done | div_done;
        end
        chk("midreset no_late_done", {31'd0, any_done}, 32'd0);

        // Start accepted in the done cycle; old result held meanwhile.
        @(negedge clk);
        div_op = 2'b01;
        rs1 = 32'd100;
        rs2 = 32'd7;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        lat = 0;
        while (div_busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b first done", {31'd0, div_done}, 32'd1);
        chk("b2b first result", div_result, 32'd14);
        div_op = 2'b11;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        chk("b2b accepted busy", {31'd0, div_busy}, 32'd1);
        chk("b2b held result", div_result, 32'd14);
        lat = 0;
        while (div_busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b busy_cycles", 32'(lat), 32'd33);
        chk("b2b second done", {31'd0, div_done}, 32'd1);
        chk("b2b second result", div_result, 32'd2);

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    a = $urandom;
                    b = $urandom;
                end
                1: begin
                    a = $urandom_range(0, 200);
                    b = $urandom_range(0, 20);
                end
                2: begin
                    a = $urandom;
                    b = $urandom_range(1, 15);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : $urandom;
                    b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
                end
                default: begin
                    a = $urandom >> $urandom_range(0, 31);
                    b = $urandom >> $urandom_range(0, 31);
                end
            endcase
            run_check($sformatf("rand%0d op%0d %h/%h", n, op, a, b),
                      op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
